cell_mem_responder: RTL and testbench

CELL_MEM_RESPONDER -- requirements
Module: cell_mem_responder

---
 rtl/cell_mem_responder_pkg.sv | 26 ++
 rtl/mem_ram_dp.sv | 29 ++
 rtl/cell_mem_responder.sv | 116 +++++++++++
 tb/tb_cell_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cell_mem_responder_pkg.sv
// Shared widths, request encodings and responder state codes for the cell memory responder.
package cell_mem_responder_pkg;

    localparam int unsigned MemAddrWidth = 10;
    localparam int unsigned MemDataWidth = 16;

    typedef logic [MemAddrWidth-1:0] mem_addr_t;
    typedef logic [MemDataWidth-1:0] mem_data_t;

    typedef enum logic [1:0] {
        FuncRead  = 2'b00,
        FuncWrite = 2'b01,
        FuncAlloc = 2'b10,
        FuncSwap  = 2'b11
    } mem_func_e;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAccess  = 2'd1;
    localparam logic [1:0] StRespond = 2'd2;
    localparam logic [1:0] StWaitLow = 2'd3;

    function automatic mem_data_t addr_to_data(input mem_addr_t addr);
        return mem_data_t'(addr);
    endfunction

endpackage

// File: rtl/mem_ram_dp.sv
// Dual-read, single-write synchronous RAM; reads return the pre-write word on a collision.
module mem_ram_dp
    import cell_mem_responder_pkg::*;
(
    input  logic      clk,
    input  logic      re,
    input  mem_addr_t raddr1,
    input  mem_addr_t raddr2,
    output mem_data_t rdata1,
    output mem_data_t rdata2,
    input  logic      we,
    input  mem_addr_t waddr,
    input  mem_data_t wdata
);

    mem_data_t mem [2**MemAddrWidth];

    // No reset: contents must survive rst.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata1 <= mem[raddr1];
            rdata2 <= mem[raddr2];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/cell_mem_responder.sv
// Four-state request/response front end for the cell RAM with a bump allocator.
module cell_mem_responder
    import cell_mem_responder_pkg::*;
#(
    parameter mem_addr_t FREE_BASE = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_execute,
    input  logic [1:0]  mem_func,
    input  mem_addr_t   address1,
    input  mem_addr_t   address2,
    input  mem_data_t   write_data,
    output logic        mem_ready,
    output mem_data_t   read_data1,
    output mem_data_t   read_data2,
    output mem_addr_t   free_addr,
    output logic [1:0]  mem_error
);

    logic [1:0] state_q, state_d;
    mem_func_e  func_q;
    mem_addr_t  addr1_q, addr2_q, free_q;
    mem_data_t  wdata_q, rd1_q, rd2_q;
    logic       full_q;
    logic [1:0] err_q;

    logic       ram_re, ram_we, do_alloc;
    mem_addr_t  ram_waddr;
    mem_data_t  ram_rdata1, ram_rdata2;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (mem_execute) state_d = StAccess;
            StAccess:  state_d = StRespond;
            StRespond: state_d = StWaitLow;
            StWaitLow: if (!mem_execute) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // RAM is driven only from captured request fields, so an async reset drops the write.
    assign ram_re    = (state_q == StAccess);
    assign do_alloc  = (func_q == FuncAlloc) && !full_q;
    assign ram_we    = ram_re && ((func_q == FuncWrite) || (func_q == FuncSwap) || do_alloc);
    assign ram_waddr = (func_q == FuncAlloc) ? free_q : addr1_q;

    mem_ram_dp u_ram (
        .clk    (clk),
        .re     (ram_re),
        .raddr1 (addr1_q),
        .raddr2 (addr2_q),
        .rdata1 (ram_rdata1),
        .rdata2 (ram_rdata2),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (wdata_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            func_q  <= FuncRead;
            addr1_q <= '0;
            addr2_q <= '0;
            wdata_q <= '0;
            free_q  <= FREE_BASE;
            full_q  <= 1'b0;
            err_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && mem_execute) begin
                func_q  <= mem_func_e'(mem_func);
                addr1_q <= address1;
                addr2_q <= address2;
                wdata_q <= write_data;
            end
            if (state_q == StAccess && func_q == FuncAlloc) begin
                rd1_q <= addr_to_data(free_q);
                if (full_q) begin
                    err_q[0] <= 1'b1;
                end else if (&free_q) begin
                    full_q <= 1'b1;
                end else begin
                    free_q <= free_q + 1'b1;
                end
            end
            if (state_q == StRespond) begin
                if (func_q == FuncRead || func_q == FuncSwap) rd1_q <= ram_rdata1;
                if (func_q == FuncRead) rd2_q <= ram_rdata2;
            end
            if ((state_q == StAccess || state_q == StRespond) && mem_execute &&
                (mem_func_e'(mem_func) != func_q)) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    // Fresh RAM words are visible during RESPOND; held copies otherwise.
    always_comb begin
        read_data1 = rd1_q;
        read_data2 = rd2_q;
        if (state_q == StRespond) begin
            if (func_q == FuncRead || func_q == FuncSwap) read_data1 = ram_rdata1;
            if (func_q == FuncRead) read_data2 = ram_rdata2;
        end
    end

    assign mem_ready = (state_q == StRespond);
    assign free_addr = free_q;
    assign mem_error = err_q;

endmodule

// File: tb/tb_cell_mem_responder.sv
// Randomized bench for cell_mem_responder against a word-array reference model.
module tb_cell_mem_responder;
    import cell_mem_responder_pkg::*;

    localparam mem_addr_t Base = 10'h3FE;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_execute;
    logic [1:0] mem_func;
    mem_addr_t  address1, address2, free_addr;
    mem_data_t  write_data, read_data1, read_data2;
    logic       mem_ready;
    logic [1:0] mem_error;

    cell_mem_responder #(.FREE_BASE(Base)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_execute(mem_execute),
        .mem_func   (mem_func),
        .address1   (address1),
        .address2   (address2),
        .write_data (write_data),
        .mem_ready  (mem_ready),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .free_addr  (free_addr),
        .mem_error  (mem_error)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model state
    int unsigned ref_mem [1024];
    int unsigned exp_rd1, exp_rd2, exp_free;
    bit          exp_full;
    logic [1:0]  exp_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        exp_rd1  = 0;
        exp_rd2  = 0;
        exp_free = Base;
        exp_full = 1'b0;
        exp_err  = 2'b00;
    endfunction

    function automatic void model_op(input logic [1:0] f, input int unsigned a1,
                                     input int unsigned a2, input int unsigned wd);
        case (f)
            2'b00: begin
                exp_rd1 = ref_mem[a1];
                exp_rd2 = ref_mem[a2];
            end
            2'b01: ref_mem[a1] = wd;
            2'b10: begin
                exp_rd1 = exp_free;
                if (exp_full) begin
                    exp_err[0] = 1'b1;
                end else begin
                    ref_mem[exp_free] = wd;
                    if (exp_free == 1023) exp_full = 1'b1;
                    else exp_free = exp_free + 1;
                end
            end
            default: begin
                exp_rd1 = ref_mem[a1];
                ref_mem[a1] = wd;
            end
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".rd1"}, read_data1, exp_rd1);
        check_eq({tag, ".rd2"}, read_data2, exp_rd2);
        check_eq({tag, ".free"}, free_addr, exp_free);
        check_eq({tag, ".err"}, mem_error, exp_err);
    endtask

    task automatic do_op(input logic [1:0] f, input mem_addr_t a1, input mem_addr_t a2,
                         input mem_data_t wd);
        mem_func    = f;
        address1    = a1;
        address2    = a2;
        write_data  = wd;
        mem_execute = 1'b1;
        tick();
        check_eq("ready_early", mem_ready, 1'b0);
        tick();
        check_eq("ready_pulse", mem_ready, 1'b1);
        model_op(f, a1, a2, wd);
        check_outputs("resp");
        mem_execute = 1'b0;
        tick();
        check_eq("ready_after", mem_ready, 1'b0);
        check_outputs("hold");
        tick();
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            do_op(2'($urandom_range(3, 0)), mem_addr_t'($urandom_range(31, 0)),
                  mem_addr_t'($urandom_range(31, 0)), mem_data_t'($urandom));
            if ($urandom_range(3, 0) == 0) tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        rst         = 1'b1;
        mem_execute = 1'b0;
        mem_func    = 2'b00;
        address1    = '0;
        address2    = '0;
        write_data  = '0;
        tick();
        tick();
        model_reset();
        check_eq("rst.ready", mem_ready, 1'b0);
        check_outputs("rst");
        rst = 1'b0;
        tick();

        for (int a = 0; a < 32; a++) do_op(2'b01, mem_addr_t'(a), '0, mem_data_t'($urandom));

        // Write then read the same word through both ports
        do_op(2'b01, 10'd5, '0, 16'h002A);
        do_op(2'b00, 10'd5, 10'd5, 16'h0);
        check_eq("same_addr.rd1", read_data1, 16'h002A);
        check_eq("same_addr.rd2", read_data2, 16'h002A);

        // Request held high for 10 cycles gives a single pulse
        mem_func    = 2'b00;
        address1    = 10'd7;
        address2    = 10'd5;
        mem_execute = 1'b1;
        pulses      = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_ready === 1'b1) pulses++;
        end
        check_eq("held.pulses", pulses, 1);
        model_op(2'b00, 7, 5, 0);
        mem_execute = 1'b0;
        tick();
        tick();
        check_outputs("held");

        do_op(2'b01, 10'd3, '0, 16'h0009);
        do_op(2'b11, 10'd3, '0, 16'h0007);
        check_eq("swap.old", read_data1, 16'h0009);
        do_op(2'b00, 10'd3, 10'd3, 16'h0);
        check_eq("swap.new", read_data1, 16'h0007);

        do_op(2'b10, '0, '0, 16'hAAAA);
        check_eq("alloc1.rd1", read_data1, 16'h03FE);
        do_op(2'b10, '0, '0, 16'hBBBB);
        check_eq("alloc2.rd1", read_data1, 16'h03FF);
        do_op(2'b10, '0, '0, 16'hCCCC);
        check_eq("alloc3.err0", mem_error[0], 1'b1);
        check_eq("alloc3.free", free_addr, 10'h3FF);
        do_op(2'b00, 10'h3FF, 10'h3FE, 16'h0);
        check_eq("alloc3.nowrite", read_data1, 16'hBBBB);

        // Function changes while ACCESS is in flight
        mem_func    = 2'b01;
        address1    = 10'd10;
        write_data  = 16'hBEEF;
        mem_execute = 1'b1;
        tick();
        mem_func = 2'b00;
        tick();
        check_eq("func_chg.ready", mem_ready, 1'b1);
        model_op(2'b01, 10, 0, 16'hBEEF);
        exp_err[1] = 1'b1;
        check_outputs("func_chg");
        mem_execute = 1'b0;
        tick();
        tick();
        do_op(2'b00, 10'd10, 10'd5, 16'h0);
        check_eq("func_chg.sticky", mem_error[1], 1'b1);

        random_ops(100);

        // Reset during ACCESS of a write, with a read request held across release
        do_op(2'b01, 10'd8, '0, 16'h0011);
        mem_func    = 2'b01;
        address1    = 10'd8;
        write_data  = 16'h0055;
        mem_execute = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("abort.ready", mem_ready, 1'b0);
        check_outputs("abort");
        mem_func = 2'b00;
        address2 = 10'd8;
        tick();
        rst = 1'b0;
        tick();
        check_eq("restart.early", mem_ready, 1'b0);
        tick();
        check_eq("restart.ready", mem_ready, 1'b1);
        model_op(2'b00, 8, 8, 0);
        check_outputs("restart");
        check_eq("abort.kept", read_data1, 16'h0011);
        mem_execute = 1'b0;
        tick();
        tick();

        random_ops(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
